// File: rtl/id_ex_stage_if.sv
// Bundle between decode/regfile/writeback and the ID/EX pipeline register.
// The master side feeds decode and writeback; the slave side is the stage itself.
interface id_ex_stage_if #(
   parameter int CTRL_W = 16
);
   logic              id_valid;
   logic [4:0]        id_ra1;
   logic [4:0]        id_ra2;
   logic [4:0]        id_wa;
   logic [31:0]       id_imm;
   logic [CTRL_W-1:0] id_ctrl;
   logic [31:0]       rd1;
   logic [31:0]       rd2;
   logic              wb_we;
   logic [4:0]        wb_wa;
   logic [31:0]       wb_wd;
   logic              stall;
   logic              flush;
   logic              load_use;
   logic              ex_valid;
   logic [31:0]       ex_op1;
   logic [31:0]       ex_op2;
   logic [4:0]        ex_ra1;
   logic [4:0]        ex_ra2;
   logic [4:0]        ex_wa;
   logic [31:0]       ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [31:0]       bubble_cnt;

   modport master (
      output id_valid, id_ra1, id_ra2, id_wa, id_imm, id_ctrl,
      output rd1, rd2, wb_we, wb_wa, wb_wd, stall, flush,
      input  load_use, ex_valid, ex_op1, ex_op2, ex_ra1, ex_ra2, ex_wa,
      input  ex_imm, ex_ctrl, bubble_cnt
   );

   modport slave (
      input  id_valid, id_ra1, id_ra2, id_wa, id_imm, id_ctrl,
      input  rd1, rd2, wb_we, wb_wa, wb_wd, stall, flush,
      output load_use, ex_valid, ex_op1, ex_op2, ex_ra1, ex_ra2, ex_wa,
      output ex_imm, ex_ctrl, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// stall/flush handling. Define BUBBLE_CNT_EN to build the saturating bubble counter.
module id_ex_stage #(
   parameter int CTRL_W   = 16,
   parameter int LOAD_BIT = 0
) (
   input logic           clk,
   input logic           rst,
   id_ex_stage_if.slave  bus
);

   logic [31:0]       w_op1;
   logic [31:0]       w_op2;
   logic              w_loadUse;
   logic              w_holdWr1;
   logic              w_holdWr2;

   logic              r_exValid;
   logic [31:0]       r_exOp1;
   logic [31:0]       r_exOp2;
   logic [4:0]        r_exRa1;
   logic [4:0]        r_exRa2;
   logic [4:0]        r_exWa;
   logic [31:0]       r_exImm;
   logic [CTRL_W-1:0] r_exCtrl;

   // Register 0 reads as zero; a same-cycle writeback beats the stale regfile read.
   always_comb begin
      w_op1 = bus.rd1;
      if (bus.id_ra1 == 5'd0)
         w_op1 = 32'd0;
      else if (bus.wb_we && (bus.wb_wa == bus.id_ra1))
         w_op1 = bus.wb_wd;
   end

   always_comb begin
      w_op2 = bus.rd2;
      if (bus.id_ra2 == 5'd0)
         w_op2 = 32'd0;
      else if (bus.wb_we && (bus.wb_wa == bus.id_ra2))
         w_op2 = bus.wb_wd;
   end

   assign w_loadUse = bus.id_valid & r_exValid & r_exCtrl[LOAD_BIT] &
                      (r_exWa != 5'd0) &
                      ((r_exWa == bus.id_ra1) | (r_exWa == bus.id_ra2)) &
                      ~bus.stall;

   assign w_holdWr1 = bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == r_exRa1);
   assign w_holdWr2 = bus.wb_we && (bus.wb_wa != 5'd0) && (bus.wb_wa == r_exRa2);

   // A held instruction keeps absorbing writebacks so it never leaves with stale operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exValid <= 1'b0;
         r_exOp1   <= 32'd0;
         r_exOp2   <= 32'd0;
         r_exRa1   <= 5'd0;
         r_exRa2   <= 5'd0;
         r_exWa    <= 5'd0;
         r_exImm   <= 32'd0;
         r_exCtrl  <= '0;
      end else if (bus.flush) begin
         r_exValid <= 1'b0;
         r_exOp1   <= 32'd0;
         r_exOp2   <= 32'd0;
         r_exRa1   <= 5'd0;
         r_exRa2   <= 5'd0;
         r_exWa    <= 5'd0;
         r_exImm   <= 32'd0;
         r_exCtrl  <= '0;
      end else if (bus.stall) begin
         if (w_holdWr1)
            r_exOp1 <= bus.wb_wd;
         if (w_holdWr2)
            r_exOp2 <= bus.wb_wd;
      end else if (w_loadUse) begin
         r_exValid <= 1'b0;
         r_exCtrl  <= '0;
      end else begin
         r_exValid <= bus.id_valid;
         r_exOp1   <= w_op1;
         r_exOp2   <= w_op2;
         r_exRa1   <= bus.id_ra1;
         r_exRa2   <= bus.id_ra2;
         r_exWa    <= bus.id_wa;
         r_exImm   <= bus.id_imm;
         r_exCtrl  <= bus.id_valid ? bus.id_ctrl : '0;
      end
   end

`ifdef BUBBLE_CNT_EN
   logic [31:0] r_bubbleCnt;

   // Flush and load-use bubbles are counted; stall cycles are not. Saturates at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_bubbleCnt <= 32'd0;
      else if ((bus.flush || w_loadUse) && (r_bubbleCnt != 32'hFFFF_FFFF))
         r_bubbleCnt <= r_bubbleCnt + 32'd1;
   end

   assign bus.bubble_cnt = r_bubbleCnt;
`else
   assign bus.bubble_cnt = 32'd0;
`endif

   assign bus.load_use = w_loadUse;
   assign bus.ex_valid = r_exValid;
   assign bus.ex_op1   = r_exOp1;
   assign bus.ex_op2   = r_exOp2;
   assign bus.ex_ra1   = r_exRa1;
   assign bus.ex_ra2   = r_exRa2;
   assign bus.ex_wa    = r_exWa;
   assign bus.ex_imm   = r_exImm;
   assign bus.ex_ctrl  = r_exCtrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, bypass, load-use bubble, stall
// writeback, flush-over-stall and asynchronous reset, against hand-computed values.
module tb_id_ex_stage;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   logic [31:0] expBubble;

   id_ex_stage_if #(.CTRL_W(16)) bus ();

   id_ex_stage #(.CTRL_W(16), .LOAD_BIT(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [4:0] ra1,
                                input logic [4:0] ra2, input logic [4:0] wa,
                                input logic [31:0] imm, input logic [15:0] ctrl,
                                input logic [31:0] rd1, input logic [31:0] rd2);
      bus.id_valid = valid;
      bus.id_ra1   = ra1;
      bus.id_ra2   = ra2;
      bus.id_wa    = wa;
      bus.id_imm   = imm;
      bus.id_ctrl  = ctrl;
      bus.rd1      = rd1;
      bus.rd2      = rd2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic countBubble();
`ifdef BUBBLE_CNT_EN
      expBubble = expBubble + 32'd1;
`endif
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      expBubble  = 32'd0;
      rst        = 1'b1;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 16'h0, 32'd0, 32'd0);
      bus.wb_we = 1'b0;
      bus.wb_wa = 5'd0;
      bus.wb_wd = 32'd0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      #22;
      checkOutput("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("rst_op1", bus.ex_op1, 32'd0);
      checkOutput("rst_bubble", bus.bubble_cnt, 32'd0);
      checkOutput("rst_load_use", {31'd0, bus.load_use}, 32'd0);
      rst = 1'b0;

      // Plain capture
      applyStimulus(1'b1, 5'd8, 5'd9, 5'd5, 32'h10, 16'h0004, 32'd6, 32'd3);
      tick();
      checkOutput("cap_valid", {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("cap_op1", bus.ex_op1, 32'd6);
      checkOutput("cap_op2", bus.ex_op2, 32'd3);
      checkOutput("cap_imm", bus.ex_imm, 32'h10);
      checkOutput("cap_wa", {27'd0, bus.ex_wa}, 32'd5);
      checkOutput("cap_ra1", {27'd0, bus.ex_ra1}, 32'd8);
      checkOutput("cap_ctrl", {16'd0, bus.ex_ctrl}, 32'h4);

      // Writeback bypass
      bus.rd1 = 32'd0;
      bus.wb_we = 1'b1; bus.wb_wa = 5'd8; bus.wb_wd = 32'h6;
      tick();
      checkOutput("byp_op1", bus.ex_op1, 32'h6);
      checkOutput("byp_op2_nomatch", bus.ex_op2, 32'd3);
      bus.id_ra1 = 5'd0; bus.rd1 = 32'd7; bus.wb_wa = 5'd0;
      tick();
      checkOutput("byp_r0", bus.ex_op1, 32'd0);
      bus.id_ra1 = 5'd8; bus.rd1 = 32'h55; bus.wb_we = 1'b0; bus.wb_wa = 5'd8;
      tick();
      checkOutput("byp_we_low", bus.ex_op1, 32'h55);

      // Capture a load writing r8, then present a dependent instruction
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd8, 32'd0, 16'h0001, 32'd1, 32'd2);
      tick();
      checkOutput("ld_ctrl", {16'd0, bus.ex_ctrl}, 32'h1);
      applyStimulus(1'b1, 5'd4, 5'd5, 5'd3, 32'd0, 16'h0002, 32'h11, 32'h22);
      #1;
      checkOutput("lu_indep", {31'd0, bus.load_use}, 32'd0);
      bus.id_ra2 = 5'd8;
      #1;
      checkOutput("lu_hit", {31'd0, bus.load_use}, 32'd1);
      bus.stall = 1'b1;
      #1;
      checkOutput("lu_stall_mask", {31'd0, bus.load_use}, 32'd0);
      bus.stall = 1'b0;
      #1;
      tick();
      countBubble();
      checkOutput("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("lu_bubble_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
      checkOutput("lu_bubble_cnt", bus.bubble_cnt, expBubble);
      checkOutput("lu_drop", {31'd0, bus.load_use}, 32'd0);
      tick();
      checkOutput("lu_cap_valid", {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("lu_cap_op2", bus.ex_op2, 32'h22);
      checkOutput("lu_cap_ctrl", {16'd0, bus.ex_ctrl}, 32'h2);

      // Stall with a writeback to the held source
      applyStimulus(1'b1, 5'd9, 5'd10, 5'd7, 32'h20, 16'h0002, 32'd3, 32'h44);
      tick();
      checkOutput("st_pre_op1", bus.ex_op1, 32'd3);
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 32'h77, 16'h0008, 32'h99, 32'h98);
      bus.stall = 1'b1;
      bus.wb_we = 1'b1; bus.wb_wa = 5'd9; bus.wb_wd = 32'hA;
      tick();
      checkOutput("st_op1", bus.ex_op1, 32'hA);
      checkOutput("st_op2", bus.ex_op2, 32'h44);
      checkOutput("st_imm", bus.ex_imm, 32'h20);
      checkOutput("st_ra1", {27'd0, bus.ex_ra1}, 32'd9);
      checkOutput("st_wa", {27'd0, bus.ex_wa}, 32'd7);
      checkOutput("st_valid", {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("st_ctrl", {16'd0, bus.ex_ctrl}, 32'h2);
      checkOutput("st_cnt", bus.bubble_cnt, expBubble);

      // Flush wins over stall
      bus.wb_we = 1'b0;
      bus.flush = 1'b1;
      tick();
      countBubble();
      checkOutput("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("fl_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
      checkOutput("fl_cnt", bus.bubble_cnt, expBubble);

      // Asynchronous reset between edges
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd5, 32'h30, 16'h0001, 32'h12, 32'h34);
      tick();
      checkOutput("ar_pre_valid", {31'd0, bus.ex_valid}, 32'd1);
      #1;
      checkOutput("ar_pre_lu", {31'd0, bus.load_use}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("ar_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("ar_op1", bus.ex_op1, 32'd0);
      checkOutput("ar_imm", bus.ex_imm, 32'd0);
      checkOutput("ar_ctrl", {16'd0, bus.ex_ctrl}, 32'd0);
      checkOutput("ar_cnt", bus.bubble_cnt, 32'd0);
      checkOutput("ar_lu", {31'd0, bus.load_use}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly downstream of the register file. It captures the two read ports (rd1/rd2) together with the decoded instruction fields and presents them to the execute stage one cycle later. It bypasses same-cycle writeback data, detects load-use hazards, and inserts bubbles. It also honours stall and flush from the hazard and branch logic.

## Interface
- CTRL_W, 16: width of the decoded control bundle.
- LOAD_BIT, 0: index in the control bundle marking a load instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_ra1, id_ra2  in  5  source register addresses, also driven to the regfile ra1/ra2.
- id_wa  in  5  destination register address.
- id_imm  in  32  sign-extended immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- rd1, rd2  in  32  regfile read data for id_ra1/id_ra2.
- wb_we, wb_wa, wb_wd  in  1/5/32  writeback port, the same signals that drive regfile we3/wa3/wd3.
- stall  in  1  hold the EX register (downstream busy).
- flush  in  1  kill the instruction entering EX (branch taken).
- load_use  out  1  combinational; upstream (PC, IF/ID) must hold this cycle.
- ex_valid  out  1  EX register holds a real instruction.
- ex_op1, ex_op2  out  32  captured operands.
- ex_ra1, ex_ra2, ex_wa  out  5  captured addresses.
- ex_imm  out  32  captured immediate.
- ex_ctrl  out  CTRL_W  captured control bundle.
- bubble_cnt  out  32  count of inserted bubbles (see Configuration).

## Operation
- **Operand select, per port n:**
  - If id_ran==0, the operand is 0.
  - Otherwise, if wb_we && wb_wa==id_ran, the operand is wb_wd (write-through bypass).
  - Otherwise the operand is rdn.
- **load_use:** asserted when id_valid & ex_valid & ex_ctrl[LOAD_BIT] & ex_wa!=0 & (ex_wa==id_ra1 | ex_wa==id_ra2), and stall is low.
- **Update priority at each edge:**
  1. **rst:** all registers are 0.
  2. **flush:** ex_valid=0 and ex_ctrl=0; the other fields are don't-care, and they are loaded with 0.
  3. **stall:** all fields are held. For each n, if wb_we && wb_wa!=0 && wb_wa==ex_ran, ex_opn is overwritten with wb_wd, so a held instruction never keeps stale operands.
  4. **load_use:** a bubble is loaded: ex_valid=0 and ex_ctrl=0.
  5. **Otherwise, capture:** ex_valid=id_valid and ex_op1/ex_op2 come from operand select. All other fields are copied from id_*. When id_valid=0, ex_ctrl is forced to 0.
- flush and stall in the same cycle: flush wins.
- A bubble created by load_use lasts exactly one cycle. On the next edge the load sits in MEM, ex_valid=0, so load_use drops and the held decode instruction is captured. At that point the bypass picks up the load result if writeback is in the same cycle; otherwise the EX forwarding path supplies it.

## Timing
- Latency: 1 cycle from id_* to ex_*.
- The only combinational paths are load_use (from id_ra*/ex_* state) and operand select (from rd*/wb_*). There is no combinational path from id_* to ex_*.
- Reset value of every registered output is 0, including bubble_cnt.
- Asserting rst mid-stall or mid-bubble clears the stage immediately (asynchronous). The first capture happens on the first rising edge after rst deasserts.
- load_use is 0 during reset, because ex_valid=0.

## Configuration
- **BUBBLE_CNT_EN defined:**
  - bubble_cnt increments by 1 on every edge where the stage loads a bubble because of load_use or flush while out of reset.
  - The counter saturates at 32'hFFFFFFFF.
  - Stall cycles are not counted.
- **BUBBLE_CNT_EN undefined:** bubble_cnt is tied to 32'h0 and no counter flops exist.

## Test plan
- **Plain capture:** reset for 22 time units, then id_valid=1, id_ra1=8, id_ra2=9, rd1=6, rd2=3, id_imm=32'h10. After 1 edge: ex_valid=1, ex_op1=6, ex_op2=3, ex_imm=32'h10.
- **WB bypass:** rd1=0 (stale), wb_we=1, wb_wa=8, wb_wd=32'h6, id_ra1=8 → ex_op1=6. Repeat with id_ra1=0 and wb_wa=0 → ex_op1=0.
- **Load-use:** EX holds a load with ex_wa=8; ID presents id_ra2=8.
  - load_use=1 in that cycle.
  - Next edge: ex_valid=0, and bubble_cnt=1 when BUBBLE_CNT_EN is defined (0 otherwise).
  - Following edge: ID instruction captured, ex_valid=1.
- **Stall with write to held source:** EX holds ex_ra1=9 and ex_op1=3; stall=1, wb_we=1, wb_wa=9, wb_wd=32'hA. After the edge: ex_op1=32'hA, all other fields unchanged.
- **Flush vs stall:** flush=1 and stall=1 together → ex_valid=0, ex_ctrl=0; bubble_cnt increments.
- **Async reset mid-operation:** with ex_valid=1, raise rst between edges. All outputs go to 0 immediately without a clock edge, and load_use=0.
